// File: rtl/riscv_mem_arbiter_if.sv
// Signal bundle between the two requesters (fetch = 0, load/store = 1),
// the memory arbiter and the single-port AXI request/response driver.
interface riscv_mem_arbiter_if;
  // requester side
  logic [1:0]       m_req_vld;
  logic [1:0]       m_req_rnw;
  logic [1:0][31:0] m_req_addr;
  logic [1:0][31:0] m_req_data;
  logic [1:0]       m_flush;
  logic [1:0]       m_req_ack;
  logic [1:0]       m_rsp_vld;
  logic [31:0]      m_rsp_addr;
  logic [31:0]      m_rsp_data;
  logic [1:0]       m_rsp_ack;

  // driver side
  logic             drv_req_vld;
  logic             drv_req_rnw;
  logic [31:0]      drv_req_addr;
  logic [31:0]      drv_req_data;
  logic             drv_req_ack;
  logic             drv_rsp_vld;
  logic [31:0]      drv_rsp_addr;
  logic [31:0]      drv_rsp_data;
  logic             drv_rsp_ack;

  // the arbiter: serves the requesters, masters the driver
  modport slave (
    input  m_req_vld, m_req_rnw, m_req_addr, m_req_data, m_flush, m_rsp_ack,
    output m_req_ack, m_rsp_vld, m_rsp_addr, m_rsp_data,
    output drv_req_vld, drv_req_rnw, drv_req_addr, drv_req_data, drv_rsp_ack,
    input  drv_req_ack, drv_rsp_vld, drv_rsp_addr, drv_rsp_data
  );

  // the environment: requesters plus driver
  modport master (
    output m_req_vld, m_req_rnw, m_req_addr, m_req_data, m_flush, m_rsp_ack,
    input  m_req_ack, m_rsp_vld, m_rsp_addr, m_rsp_data,
    input  drv_req_vld, drv_req_rnw, drv_req_addr, drv_req_data, drv_rsp_ack,
    output drv_req_ack, drv_rsp_vld, drv_rsp_addr, drv_rsp_data
  );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Two-requester arbiter in front of the AXI driver; in-order owner FIFO routes
// responses back. Define RISCV_MEM_ARB_RR_EN for round-robin instead of 1 > 0.
module riscv_mem_arbiter #(
  parameter int unsigned OUTSTANDING = 16,
  parameter int unsigned PTR_W       = $clog2(OUTSTANDING)
) (
  input  logic                clock,
  input  logic                reset,
  riscv_mem_arbiter_if.slave  bus
);

  typedef enum logic {
    ST_OPEN,
    ST_LOCKED
  } lock_state_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(OUTSTANDING);

  lock_state_t              state_q, state_d;
  logic                     lock_port_q, lock_port_d;

  logic [OUTSTANDING-1:0]   own_q;
  logic [OUTSTANDING-1:0]   disc_q;
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [PTR_W:0]           count;

  logic                     full;
  logic                     grant;
  logic                     req_vld;
  logic                     accept;
  logic                     head_owner;
  logic                     head_drop;
  logic                     rsp_live;
  logic                     push;
  logic                     pop;

`ifdef RISCV_MEM_ARB_RR_EN
  logic                     rr_ptr;
`endif

  assign full = (count == FULL_CNT);

  // Grant selection: held while locked, otherwise arbitrate among requesters.
  always_comb begin
    grant = 1'b0;
    if (state_q == ST_LOCKED) begin
      grant = lock_port_q;
    end else begin
`ifdef RISCV_MEM_ARB_RR_EN
      if (&bus.m_req_vld) grant = rr_ptr;
      else                grant = bus.m_req_vld[1];
`else
      grant = bus.m_req_vld[1];
`endif
    end
  end

  // A flush retracts a stalled (locked) request; a fresh request accepted in
  // the flush cycle still issues and is pushed pre-discarded instead.
  always_comb begin
    req_vld = ~reset & ~full & bus.m_req_vld[grant];
    if (state_q == ST_LOCKED && bus.m_flush[grant]) req_vld = 1'b0;
  end

  assign accept = req_vld & bus.drv_req_ack;

  assign bus.drv_req_vld  = req_vld;
  assign bus.drv_req_rnw  = bus.m_req_rnw[grant];
  assign bus.drv_req_addr = bus.m_req_addr[grant];
  assign bus.drv_req_data = bus.m_req_data[grant];
  assign bus.m_req_ack    = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;

  // Lock FSM next state: lock whenever the driver stalls a valid request.
  always_comb begin
    state_d     = ST_OPEN;
    lock_port_d = lock_port_q;
    if (req_vld && !bus.drv_req_ack) begin
      state_d     = ST_LOCKED;
      lock_port_d = grant;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_OPEN;
      lock_port_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_port_q <= lock_port_d;
    end
  end

`ifdef RISCV_MEM_ARB_RR_EN
  always_ff @(posedge clock) begin
    if (reset)       rr_ptr <= 1'b0;
    else if (accept) rr_ptr <= ~grant;
  end
`endif

  // Response routing from the FIFO head.
  assign head_owner = own_q[rd_ptr];
  assign head_drop  = disc_q[rd_ptr] | bus.m_flush[head_owner];
  assign rsp_live   = ~reset & bus.drv_rsp_vld & (count != '0);

  always_comb begin
    bus.m_rsp_vld = 2'b00;
    if (rsp_live && !head_drop) bus.m_rsp_vld[head_owner] = 1'b1;
  end

  assign bus.m_rsp_addr  = bus.drv_rsp_addr;
  assign bus.m_rsp_data  = bus.drv_rsp_data;
  assign bus.drv_rsp_ack = rsp_live & (head_drop | bus.m_rsp_ack[head_owner]);

  assign push = accept;
  assign pop  = bus.drv_rsp_ack;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Stale (non-valid) slots may also be marked; the push rewrites them anyway.
  always_ff @(posedge clock) begin
    if (reset) begin
      own_q  <= '0;
      disc_q <= '0;
    end else begin
      for (int unsigned i = 0; i < OUTSTANDING; i++) begin
        if (bus.m_flush[own_q[i]]) disc_q[i] <= 1'b1;
      end
      if (push) begin
        own_q[wr_ptr]  <= grant;
        disc_q[wr_ptr] <= bus.m_flush[grant];
      end
    end
  end

endmodule
